// File: rtl/bus_pkg.sv
// Shared types and constants for the switch-driven Wishbone test master.
// Used by bus_sw_master and its helpers.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 16;

    localparam logic [15:0] LED_ERR_PATTERN = 16'hFFFF;

    // LED image: error pattern wins over the done/read-data view.
    function automatic logic [15:0] led_value(input logic        done,
                                              input logic        err,
                                              input logic [14:0] rd_lo);
        return err ? LED_ERR_PATTERN : {done, rd_lo};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-button conditioner: synchronizer chain, stability counter and a
// one-cycle pulse on each accepted rising edge.
module sw_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= btn_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Any agreement with the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/bus_sw_master.sv
// Switch-driven Wishbone master: one transaction per debounced button press.
// Define BUS_SW_MASTER_TIMEOUT_EN to bound the wait for wb_ack_i.
module bus_sw_master
    import bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned TIMEOUT_CYCLES  = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           sw_addr,
    input  logic [7:0]           sw_data,
    input  logic [7:0]           sw_sel,
    input  logic                 sw_we,
    input  logic                 btn_go,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [WB_ADDR_W-1:0] wb_addr_o,
    output logic [WB_DATA_W-1:0] wb_data_o,
    output logic [WB_SEL_W-1:0]  wb_select_o,
    input  logic [WB_DATA_W-1:0] wb_data_i,
    input  logic                 wb_ack_i,
    output logic [WB_DATA_W-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [15:0]          led
);

    localparam int unsigned SW_W = 25;

    logic [SW_W-1:0] sw_sync_q [SYNC_STAGES];
    logic [SW_W-1:0] sw_s;
    logic            go;
    logic            btn_level;

    state_e                state_q;
    logic                  wb_cyc_q;
    logic                  wb_stb_q;
    logic                  wb_we_q;
    logic [WB_ADDR_W-1:0]  wb_addr_q;
    logic [WB_DATA_W-1:0]  wb_data_q;
    logic [WB_SEL_W-1:0]   wb_sel_q;
    logic [WB_DATA_W-1:0]  rd_data_q;
    logic                  done_q;

    sw_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_i   (btn_go),
        .level_o (btn_level),
        .rise_o  (go)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= '0;
            end
        end else begin
            sw_sync_q[0] <= {sw_we, sw_sel, sw_data, sw_addr};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
        end
    end

    assign sw_s = sw_sync_q[SYNC_STAGES-1];

`ifdef BUS_SW_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wb_cyc_q  <= 1'b0;
            wb_stb_q  <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
`ifdef BUS_SW_MASTER_TIMEOUT_EN
            to_cnt_q  <= '0;
            to_err_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        wb_addr_q <= WB_ADDR_W'(sw_s[7:0]);
                        wb_data_q <= WB_DATA_W'(sw_s[15:8]);
                        wb_sel_q  <= WB_SEL_W'(sw_s[23:16]);
                        wb_we_q   <= sw_s[24];
                        wb_cyc_q  <= 1'b1;
                        wb_stb_q  <= 1'b1;
                        done_q    <= 1'b0;
`ifdef BUS_SW_MASTER_TIMEOUT_EN
                        to_cnt_q  <= '0;
                        to_err_q  <= 1'b0;
`endif
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a coincident expiry.
                    if (wb_ack_i) begin
                        wb_cyc_q <= 1'b0;
                        wb_stb_q <= 1'b0;
                        done_q   <= 1'b1;
                        if (!wb_we_q) begin
                            rd_data_q <= wb_data_i;
                        end
                        state_q  <= RELEASE;
                    end
`ifdef BUS_SW_MASTER_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        wb_cyc_q <= 1'b0;
                        wb_stb_q <= 1'b0;
                        to_err_q <= 1'b1;
                        state_q  <= RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS_SW_MASTER_TIMEOUT_EN
    assign timeout_err = to_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

    assign wb_cyc_o    = wb_cyc_q;
    assign wb_stb_o    = wb_stb_q;
    assign wb_we_o     = wb_we_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_select_o = wb_sel_q;
    assign rd_data     = rd_data_q;
    assign busy        = wb_cyc_q;
    assign done        = done_q;
    assign led         = led_value(done_q, timeout_err, rd_data_q[14:0]);

endmodule
